// File: rtl/bist_pkg.sv
// Shared definitions for the BIST signature analyzer: FSM encoding, default
// widths/taps and the bit order of the packed CUT response word.
package bist_pkg;

  localparam int          BIST_SIG_W  = 16;
  localparam int          BIST_RESP_W = 9;
  localparam logic [15:0] BIST_POLY   = 16'h1021;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_CHECK = 2'd2,
    ST_DONE  = 2'd3
  } bist_state_e;

  // Response packing: {fz_L, cut_lclk, cut_read_a[4:0], cut_test_out[1:0]}
  localparam int RESP_FZ_L_BIT   = 8;
  localparam int RESP_LCLK_BIT   = 7;
  localparam int RESP_READ_A_LSB = 2;
  localparam int RESP_TEST_LSB   = 0;

  function automatic logic [BIST_RESP_W-1:0] pack_resp(
    input logic       fz_l,
    input logic       cut_lclk,
    input logic [4:0] cut_read_a,
    input logic [1:0] cut_test_out
  );
    logic [BIST_RESP_W-1:0] r;
    r = '0;
    r[RESP_FZ_L_BIT]                      = fz_l;
    r[RESP_LCLK_BIT]                      = cut_lclk;
    r[RESP_READ_A_LSB +: 5]               = cut_read_a;
    r[RESP_TEST_LSB +: 2]                 = cut_test_out;
    return r;
  endfunction

endpackage

// File: rtl/misr_reg.sv
// Multiple-input signature register: shift left, fold the outgoing MSB back
// through POLY, and XOR in the zero-extended response word.
module misr_reg
  import bist_pkg::*;
#(
  parameter int             SIG_W  = BIST_SIG_W,
  parameter int             RESP_W = BIST_RESP_W,
  parameter logic [SIG_W-1:0] POLY = BIST_POLY,
  parameter logic [SIG_W-1:0] SEED = '0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load,
  input  logic [SIG_W-1:0]  seed,
  input  logic              shift_en,
  input  logic [RESP_W-1:0] din,
  output logic [SIG_W-1:0]  q
);

  logic [SIG_W-1:0] sig_q;
  logic [SIG_W-1:0] sig_d;

  // Next signature: load has priority over compaction; otherwise hold.
  always_comb begin
    sig_d = sig_q;
    if (load) begin
      sig_d = seed;
    end else if (shift_en) begin
      sig_d = {sig_q[SIG_W-2:0], 1'b0}
            ^ (sig_q[SIG_W-1] ? POLY : '0)
            ^ SIG_W'(din);
    end
  end

  // Signature register; reset value matches the run seed.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) sig_q <= SEED;
    else       sig_q <= sig_d;
  end

  assign q = sig_q;

endmodule

// File: rtl/bist_signature_analyzer.sv
// BIST response compaction and verdict: start-edge detect, pattern counter,
// run sequencing FSM and golden-signature comparator around a MISR.
//
//   state | meaning
//   IDLE  | after reset, waiting for a start edge
//   RUN   | compacting valid responses until NUM_PATTERNS seen
//   CHECK | one cycle: compare signature with golden value
//   DONE  | verdict held; a new start edge begins another run
module bist_signature_analyzer
  import bist_pkg::*;
#(
  parameter int               SIG_W        = BIST_SIG_W,
  parameter int               RESP_W       = BIST_RESP_W,
  parameter logic [SIG_W-1:0] POLY         = BIST_POLY,
  parameter logic [SIG_W-1:0] SEED         = '0,
  parameter int               NUM_PATTERNS = 256,
  parameter logic [SIG_W-1:0] GOLDEN_SIG   = '0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              resp_valid,
  input  logic [RESP_W-1:0] resp,
  output logic              busy,
  output logic              bist_end,
  output logic              pass_nfail,
  output logic [SIG_W-1:0]  signature
);

  localparam int             CNT_W    = $clog2(NUM_PATTERNS + 1);
  localparam logic [CNT_W-1:0] LAST_M1 = CNT_W'(NUM_PATTERNS - 1);

  bist_state_e      state_q;
  logic             start_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;
  logic             bist_end_q;
  logic             pass_q;

  logic start_rise;
  logic misr_load;
  logic misr_shift;

  assign start_rise = start & ~start_q;
  // A start edge is only honoured when no run is in flight.
  assign misr_load  = start_rise && (state_q == ST_IDLE || state_q == ST_DONE);
  assign misr_shift = (state_q == ST_RUN) && resp_valid;

  misr_reg #(
    .SIG_W  (SIG_W),
    .RESP_W (RESP_W),
    .POLY   (POLY),
    .SEED   (SEED)
  ) u_misr (
    .clock    (clock),
    .reset    (reset),
    .load     (misr_load),
    .seed     (SEED),
    .shift_en (misr_shift),
    .din      (resp),
    .q        (signature)
  );

  // Run sequencing FSM with counter, edge detect and registered verdict.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      start_q    <= 1'b0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      bist_end_q <= 1'b0;
      pass_q     <= 1'b0;
    end else begin
      start_q <= start;
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start_rise) begin
            state_q    <= ST_RUN;
            cnt_q      <= '0;
            busy_q     <= 1'b1;
            bist_end_q <= 1'b0;
            pass_q     <= 1'b0;
          end
        end
        ST_RUN: begin
          if (resp_valid) begin
            cnt_q <= cnt_q + CNT_W'(1);
            if (cnt_q == LAST_M1) state_q <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          pass_q     <= (signature == GOLDEN_SIG);
          bist_end_q <= 1'b1;
          busy_q     <= 1'b0;
          state_q    <= ST_DONE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy       = busy_q;
  assign bist_end   = bist_end_q;
  assign pass_nfail = pass_q;

endmodule
